// File: rtl/data_memory_param.sv
// Parametrised single-port data memory with per-byte write enables, registered read,
// out-of-range detection and a hardware init sequencer that fills every word with INIT_VALUE.
module data_memory_param #(
   parameter int unsigned           DATA_WIDTH = 64,
   parameter int unsigned           DEPTH      = 32,
   parameter int unsigned           ADDR_WIDTH = 64,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = DATA_WIDTH'(5)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    read,
   input  logic                    write,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [DATA_WIDTH-1:0]   writeData,
   input  logic [DATA_WIDTH/8-1:0] byteEnable,
   output logic [DATA_WIDTH-1:0]   readData,
   output logic                    readValid,
   output logic                    ready,
   output logic                    error
);

   localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
   localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [0:0] {S_INIT, S_IDLE} state_t;

   state_t                r_state;
   logic [IDX_W-1:0]      r_init_index;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  w_valid_addr;
   logic [IDX_W-1:0]      w_idx;
   logic                  w_last_init;
   logic                  w_idle;
   logic                  w_do_write;
   logic                  w_do_read;
   logic                  w_bad_access;

   // Range check is done on the full address so high bits cannot alias into the array.
   assign w_valid_addr = (address < ADDR_WIDTH'(DEPTH));
   assign w_idx        = address[IDX_W-1:0];
   assign w_last_init  = (r_init_index == IDX_W'(DEPTH - 1));
   assign w_idle       = (r_state == S_IDLE);
   assign w_do_write   = w_idle && write && w_valid_addr;
   assign w_do_read    = w_idle && read;
   assign w_bad_access = w_idle && (read || write) && !w_valid_addr;

   // Storage: init fill or masked port write; contents are deliberately not reset.
   always_ff @(posedge clock) begin
      if (r_state == S_INIT && !reset) begin
         r_mem[r_init_index] <= INIT_VALUE;
      end else if (w_do_write) begin
         for (int b = 0; b < NUM_BYTES; b++) begin
            if (byteEnable[b]) begin
               r_mem[w_idx][b*8 +: 8] <= writeData[b*8 +: 8];
            end
         end
      end
   end

   // Control FSM with registered outputs; reads sample the pre-write word (read-first).
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= S_INIT;
         r_init_index <= '0;
         readData     <= '0;
         readValid    <= 1'b0;
         ready        <= 1'b0;
         error        <= 1'b0;
      end else begin
         readValid <= 1'b0;
         error     <= 1'b0;
         case (r_state)
            S_INIT: begin
               if (w_last_init) begin
                  r_state <= S_IDLE;
                  ready   <= 1'b1;
               end else begin
                  r_init_index <= r_init_index + IDX_W'(1);
               end
            end
            S_IDLE: begin
               if (w_do_read) begin
                  readData  <= w_valid_addr ? r_mem[w_idx] : '0;
                  readValid <= 1'b1;
               end
               error <= w_bad_access;
               if (clear) begin
                  r_state      <= S_INIT;
                  r_init_index <= '0;
                  ready        <= 1'b0;
               end
            end
            default: begin
               r_state      <= S_INIT;
               r_init_index <= '0;
               ready        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_param.sv
// Directed self-checking bench for data_memory_param at default parameters.
module tb_data_memory_param;

   logic        clock;
   logic        reset;
   logic        clear;
   logic        read;
   logic        write;
   logic [63:0] address;
   logic [63:0] writeData;
   logic [7:0]  byteEnable;
   logic [63:0] readData;
   logic        readValid;
   logic        ready;
   logic        error;

   int checks;
   int failures;

   data_memory_param dut (
      .clock      (clock),
      .reset      (reset),
      .clear      (clear),
      .read       (read),
      .write      (write),
      .address    (address),
      .writeData  (writeData),
      .byteEnable (byteEnable),
      .readData   (readData),
      .readValid  (readValid),
      .ready      (ready),
      .error      (error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one edge; inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      clear      = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
      address    = '0;
      writeData  = '0;
      byteEnable = '0;
   endtask

   task automatic test_reset();
      int n;
      logic strobe_seen;
      reset = 1'b1;
      idle_inputs();
      tick();
      tick();
      checks++;
      if (readData !== 64'd0 || readValid !== 1'b0 || ready !== 1'b0 || error !== 1'b0) begin
         failures++;
         $display("FAIL reset_values: readData=%h readValid=%b ready=%b error=%b, required 0/0/0/0",
                  readData, readValid, ready, error);
      end
      reset   = 1'b0;
      read    = 1'b1;
      address = 64'd40;
      n = 0;
      strobe_seen = 1'b0;
      while (ready !== 1'b1 && n < 100) begin
         tick();
         n++;
         if (readValid !== 1'b0 || error !== 1'b0) strobe_seen = 1'b1;
      end
      idle_inputs();
      checks++;
      if (n != 32) begin
         failures++;
         $display("FAIL init_length: ready after %0d cycles, required 32", n);
      end
      checks++;
      if (strobe_seen) begin
         failures++;
         $display("FAIL init_strobes: readValid/error seen during init, required none");
      end
   endtask

   task automatic test_init_reads();
      logic [63:0] addrs [3];
      addrs[0] = 64'd0;
      addrs[1] = 64'd17;
      addrs[2] = 64'd31;
      for (int i = 0; i < 3; i++) begin
         read    = 1'b1;
         address = addrs[i];
         tick();
         checks++;
         if (readValid !== 1'b1 || readData !== 64'd5) begin
            failures++;
            $display("FAIL init_read_%0d: readValid=%b readData=%h, required 1/%h",
                     addrs[i], readValid, readData, 64'd5);
         end
      end
      idle_inputs();
      tick();
      checks++;
      if (readValid !== 1'b0 || readData !== 64'd5) begin
         failures++;
         $display("FAIL read_hold: readValid=%b readData=%h, required 0/%h", readValid, readData, 64'd5);
      end
   endtask

   task automatic test_byte_enable();
      write      = 1'b1;
      address    = 64'd3;
      writeData  = 64'h1122334455667788;
      byteEnable = 8'h0F;
      tick();
      idle_inputs();
      read    = 1'b1;
      address = 64'd3;
      tick();
      idle_inputs();
      checks++;
      if (readValid !== 1'b1 || readData !== 64'h0000000055667788) begin
         failures++;
         $display("FAIL byte_enable: readValid=%b readData=%h, required 1/%h",
                  readValid, readData, 64'h0000000055667788);
      end
      write      = 1'b1;
      address    = 64'd4;
      writeData  = 64'hFFFFFFFFFFFFFFFF;
      byteEnable = 8'h00;
      tick();
      idle_inputs();
      read    = 1'b1;
      address = 64'd4;
      tick();
      idle_inputs();
      checks++;
      if (readData !== 64'd5) begin
         failures++;
         $display("FAIL byte_enable_zero: readData=%h, required %h", readData, 64'd5);
      end
   endtask

   task automatic test_read_first();
      read       = 1'b1;
      write      = 1'b1;
      address    = 64'd7;
      writeData  = 64'hAA;
      byteEnable = 8'hFF;
      tick();
      idle_inputs();
      checks++;
      if (readValid !== 1'b1 || readData !== 64'd5) begin
         failures++;
         $display("FAIL read_first_old: readValid=%b readData=%h, required 1/%h", readValid, readData, 64'd5);
      end
      read    = 1'b1;
      address = 64'd7;
      tick();
      idle_inputs();
      checks++;
      if (readValid !== 1'b1 || readData !== 64'hAA) begin
         failures++;
         $display("FAIL read_first_new: readValid=%b readData=%h, required 1/%h", readValid, readData, 64'hAA);
      end
   endtask

   task automatic test_out_of_range();
      write      = 1'b1;
      address    = 64'd40;
      writeData  = 64'hFF;
      byteEnable = 8'hFF;
      tick();
      idle_inputs();
      checks++;
      if (error !== 1'b1 || readValid !== 1'b0) begin
         failures++;
         $display("FAIL oor_write: error=%b readValid=%b, required 1/0", error, readValid);
      end
      tick();
      checks++;
      if (error !== 1'b0) begin
         failures++;
         $display("FAIL oor_pulse: error=%b, required 0", error);
      end
      read    = 1'b1;
      address = 64'd40;
      tick();
      idle_inputs();
      checks++;
      if (error !== 1'b1 || readValid !== 1'b1 || readData !== 64'd0) begin
         failures++;
         $display("FAIL oor_read: error=%b readValid=%b readData=%h, required 1/1/0",
                  error, readValid, readData);
      end
      read    = 1'b1;
      address = 64'd8;
      tick();
      idle_inputs();
      checks++;
      if (error !== 1'b0 || readData !== 64'd5) begin
         failures++;
         $display("FAIL oor_spot_word8: error=%b readData=%h, required 0/%h", error, readData, 64'd5);
      end
      read       = 1'b1;
      write      = 1'b1;
      address    = 64'h8000000000000000;
      writeData  = 64'h1;
      byteEnable = 8'hFF;
      tick();
      idle_inputs();
      checks++;
      if (error !== 1'b1 || readData !== 64'd0) begin
         failures++;
         $display("FAIL oor_both: error=%b readData=%h, required 1/0", error, readData);
      end
      tick();
      checks++;
      if (error !== 1'b0) begin
         failures++;
         $display("FAIL oor_both_single_pulse: error=%b, required 0", error);
      end
      read    = 1'b1;
      address = 64'd0;
      tick();
      idle_inputs();
      checks++;
      if (readData !== 64'd5) begin
         failures++;
         $display("FAIL oor_alias_word0: readData=%h, required %h", readData, 64'd5);
      end
   endtask

   task automatic test_clear();
      int n;
      write      = 1'b1;
      address    = 64'd2;
      writeData  = 64'h99;
      byteEnable = 8'hFF;
      tick();
      idle_inputs();
      clear   = 1'b1;
      read    = 1'b1;
      address = 64'd2;
      tick();
      idle_inputs();
      checks++;
      if (ready !== 1'b0 || readValid !== 1'b1 || readData !== 64'h99) begin
         failures++;
         $display("FAIL clear_same_cycle_read: ready=%b readValid=%b readData=%h, required 0/1/%h",
                  ready, readValid, readData, 64'h99);
      end
      write      = 1'b1;
      address    = 64'd2;
      writeData  = 64'h77;
      byteEnable = 8'hFF;
      n = 0;
      while (ready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      idle_inputs();
      checks++;
      if (n != 32) begin
         failures++;
         $display("FAIL clear_init_length: ready after %0d cycles, required 32", n);
      end
      read    = 1'b1;
      address = 64'd2;
      tick();
      idle_inputs();
      checks++;
      if (readValid !== 1'b1 || readData !== 64'd5) begin
         failures++;
         $display("FAIL clear_refill: readValid=%b readData=%h, required 1/%h", readValid, readData, 64'd5);
      end
   endtask

   task automatic test_reset_mid_init();
      int n;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      reset = 1'b1;
      tick();
      checks++;
      if (ready !== 1'b0) begin
         failures++;
         $display("FAIL mid_init_reset_ready: ready=%b, required 0", ready);
      end
      reset = 1'b0;
      n = 0;
      while (ready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (n != 32) begin
         failures++;
         $display("FAIL mid_init_reset_length: ready after %0d cycles, required 32", n);
      end
      read    = 1'b1;
      address = 64'd31;
      tick();
      idle_inputs();
      checks++;
      if (readValid !== 1'b1 || readData !== 64'd5) begin
         failures++;
         $display("FAIL mid_init_reset_read31: readValid=%b readData=%h, required 1/%h",
                  readValid, readData, 64'd5);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      idle_inputs();
      @(negedge clock);
      test_reset();
      test_init_reads();
      test_byte_enable();
      test_read_first();
      test_out_of_range();
      test_clear();
      test_reset_mid_init();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
